alu: RTL and testbench

// - 32-bit integer ALU for the rysy RV32I core execute stage.
// - Computes one of 12 operations on two register-width operands, selected by a 4-bit alu_op.
// - The result is registered: it appears on alu_out one clock after the operands and opcode are sampled.
// - The decoder drives alu_op; the writeback/branch logic consumes alu_out.
//

---
 rtl/alu.sv | 69 ++++++
 tb/tb_alu.sv | 114 +++++++++++
 2 files changed

// File: rtl/alu.sv
// Execute-stage integer ALU: 12 operations on two register-width operands.
// The result is computed combinationally and registered once (1-cycle latency).
module alu #(
  parameter int REG_LEN = 32,
  parameter int SHAMT_W = $clog2(REG_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_LEN-1:0] alu_in1,
  input  logic [REG_LEN-1:0] alu_in2,
  input  logic [3:0]         alu_op,
  output logic [REG_LEN-1:0] alu_out
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_SLL   = 4'b0010;
  localparam logic [3:0] OP_SLT   = 4'b0011;
  localparam logic [3:0] OP_SLTU  = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_OR    = 4'b1000;
  localparam logic [3:0] OP_AND   = 4'b1001;
  localparam logic [3:0] OP_PASSB = 4'b1010;
  localparam logic [3:0] OP_PASSA = 4'b1011;

  logic [SHAMT_W-1:0] w_shamt;
  logic               w_lt_s;
  logic               w_lt_u;
  logic [REG_LEN-1:0] w_result;
  logic [REG_LEN-1:0] r_result;

  // Only the low shift-amount bits matter; upper bits of operand B are ignored.
  assign w_shamt = alu_in2[SHAMT_W-1:0];
  assign w_lt_s  = $signed(alu_in1) < $signed(alu_in2);
  assign w_lt_u  = alu_in1 < alu_in2;

  always_comb begin
    w_result = '0;
    case (alu_op)
      OP_ADD:   w_result = alu_in1 + alu_in2;
      OP_SUB:   w_result = alu_in1 - alu_in2;
      OP_SLL:   w_result = alu_in1 << w_shamt;
      OP_SLT:   w_result = {{(REG_LEN-1){1'b0}}, w_lt_s};
      OP_SLTU:  w_result = {{(REG_LEN-1){1'b0}}, w_lt_u};
      OP_XOR:   w_result = alu_in1 ^ alu_in2;
      OP_SRL:   w_result = alu_in1 >> w_shamt;
      OP_SRA:   w_result = $unsigned($signed(alu_in1) >>> w_shamt);
      OP_OR:    w_result = alu_in1 | alu_in2;
      OP_AND:   w_result = alu_in1 & alu_in2;
      OP_PASSB: w_result = alu_in2;
      OP_PASSA: w_result = alu_in1;
      default:  w_result = '0;
    endcase
  end

  // Reset is asynchronous so the output clears without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
    end else begin
      r_result <= w_result;
    end
  end

  assign alu_out = r_result;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: reset behaviour, every opcode, wrap/shift/compare
// boundaries and a back-to-back sweep across all 16 opcodes.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;

  int n_cmp = 0;
  int n_err = 0;

  alu dut (
    .clk     (clk),
    .rst     (rst),
    .alu_in1 (alu_in1),
    .alu_in2 (alu_in2),
    .alu_op  (alu_op),
    .alu_out (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Drive one operation away from the rising edge, then sample just after it.
  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [31:0] exp);
    @(negedge clk);
    alu_in1 = a;
    alu_in2 = b;
    alu_op  = op;
    @(posedge clk);
    #1;
    check(tag, alu_out, exp);
  endtask

  logic [31:0] sweep_exp [16];

  initial begin
    rst     = 1'b1;
    alu_in1 = '0;
    alu_in2 = '0;
    alu_op  = '0;
    #2;
    check("reset_init", alu_out, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Load a known value, then assert reset mid-cycle.
    apply("preload", 32'h12345678, 32'h0, 4'b0000, 32'h12345678);
    #3;
    rst = 1'b1;
    #1;
    check("async_clear", alu_out, 32'h0);
    alu_in1 = 'x;
    alu_in2 = 'x;
    alu_op  = 'x;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset_hold", alu_out, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    apply("add_1_2",     32'h1, 32'h2, 4'b0000, 32'h3);
    apply("add_0_0",     32'h0, 32'h0, 4'b0000, 32'h0);
    apply("add_wrap",    32'hFFFFFFFF, 32'h1, 4'b0000, 32'h0);
    apply("sub_wrap",    32'h0, 32'h1, 4'b0001, 32'hFFFFFFFF);
    apply("slt_neg",     32'hFFFFFFFF, 32'h1, 4'b0011, 32'h1);
    apply("sltu_big",    32'hFFFFFFFF, 32'h1, 4'b0100, 32'h0);
    apply("slt_eq",      32'h5, 32'h5, 4'b0011, 32'h0);
    apply("sltu_eq",     32'h5, 32'h5, 4'b0100, 32'h0);
    apply("sltu_small",  32'h1, 32'hFFFFFFFF, 4'b0100, 32'h1);
    apply("srl_31",      32'h80000000, 32'h3F, 4'b0110, 32'h00000001);
    apply("sra_31",      32'h80000000, 32'h3F, 4'b0111, 32'hFFFFFFFF);
    apply("sll_31",      32'h1, 32'h1F, 4'b0010, 32'h80000000);
    apply("sll_sh0",     32'h80000001, 32'h20, 4'b0010, 32'h80000001);
    apply("srl_sh0",     32'h80000001, 32'h20, 4'b0110, 32'h80000001);
    apply("sra_sh0",     32'h80000001, 32'h20, 4'b0111, 32'h80000001);
    apply("xor",         32'hF0F0F0F0, 32'hFF00FF00, 4'b0101, 32'h0FF00FF0);
    apply("or",          32'hF0F0F0F0, 32'hFF00FF00, 4'b1000, 32'hFFF0FFF0);
    apply("and",         32'hF0F0F0F0, 32'hFF00FF00, 4'b1001, 32'hF000F000);
    apply("passb",       32'hF0F0F0F0, 32'hFF00FF00, 4'b1010, 32'hFF00FF00);
    apply("passa",       32'hF0F0F0F0, 32'hFF00FF00, 4'b1011, 32'hF0F0F0F0);
    apply("reserved_f",  32'hF0F0F0F0, 32'hFF00FF00, 4'b1111, 32'h0);

    // Back-to-back sweep, in1=0x80000010, in2=4; one new opcode per cycle.
    sweep_exp = '{32'h80000014, 32'h8000000C, 32'h00000100, 32'h00000001,
                  32'h00000000, 32'h80000014, 32'h08000001, 32'hF8000001,
                  32'h80000014, 32'h00000000, 32'h00000004, 32'h80000010,
                  32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    for (int i = 0; i < 16; i++) begin
      apply($sformatf("sweep_op%0d", i), 32'h80000010, 32'h4, 4'(i), sweep_exp[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
